// File: rtl/unidade_pc.sv
// unidade_pc - program counter / next-address stage for the 32-bit lab datapath.
//
// Picks the next instruction address from the branch flag of the ULA and the
// decode flags of the control unit. It also sequences halt, the input-wait
// stall and OS preemption (context switch).
//
// Ports:
//   clock, reset           rising-edge clock; synchronous active-high reset
//   igual                  resolved branch condition from the ULA
//   desvio                 conditional branch in flight
//   salto / salto_reg      jump to endereco_imediato / endereco_reg
//   endereco_imediato      jump/branch target
//   endereco_reg           register jump target
//   halt                   halt instruction (only reset leaves PARADO)
//   espera_entrada         input instruction; stall until confirma_entrada
//   confirma_entrada       input confirmation
//   troca_contexto         preemption request
//   pc                     current instruction address
//   pc_salvo               return address captured at the last context switch
//   parado / aguardando    state flags (PARADO / ESPERA)
//   erro_endereco          one-cycle pulse when a taken target is out of range
module unidade_pc #(
    parameter int LARGURA      = 32,
    parameter int PC_INICIAL   = 0,
    parameter int LIMITE_INSTR = 1024,
    parameter int ENDERECO_SO  = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               igual,
    input  logic               desvio,
    input  logic               salto,
    input  logic               salto_reg,
    input  logic [LARGURA-1:0] endereco_imediato,
    input  logic [LARGURA-1:0] endereco_reg,
    input  logic               halt,
    input  logic               espera_entrada,
    input  logic               confirma_entrada,
    input  logic               troca_contexto,
    output logic [LARGURA-1:0] pc,
    output logic [LARGURA-1:0] pc_salvo,
    output logic               parado,
    output logic               aguardando,
    output logic               erro_endereco
);

    localparam logic [LARGURA-1:0] LIMITE  = LARGURA'(LIMITE_INSTR);
    localparam logic [LARGURA-1:0] PC_INI  = LARGURA'(PC_INICIAL);
    localparam logic [LARGURA-1:0] END_SO  = LARGURA'(ENDERECO_SO);

    typedef enum logic [1:0] {
        EXECUTANDO = 2'd0,
        ESPERA     = 2'd1,
        PARADO     = 2'd2
    } estado_t;

    estado_t            estado;
    logic [LARGURA-1:0] pc_inc;
    logic [LARGURA-1:0] pc_mais1;
    logic [LARGURA-1:0] alvo;
    logic               salta;

    // Sequential successor, wrapped at the end of instruction memory.
    always_comb begin
        pc_inc   = pc + LARGURA'(1);
        pc_mais1 = (pc_inc >= LIMITE) ? '0 : pc_inc;
    end

    // salto_reg outranks the immediate forms; salto and a taken branch share
    // the immediate target.
    always_comb begin
        salta = salto_reg | salto | (desvio & igual);
        alvo  = salto_reg ? endereco_reg : endereco_imediato;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= EXECUTANDO;
            pc            <= PC_INI;
            pc_salvo      <= '0;
            parado        <= 1'b0;
            aguardando    <= 1'b0;
            erro_endereco <= 1'b0;
        end else begin
            erro_endereco <= 1'b0;
            case (estado)
                EXECUTANDO: begin
                    if (troca_contexto) begin
                        pc_salvo <= pc_mais1;
                        pc       <= END_SO;
                    end else if (halt) begin
                        estado <= PARADO;
                        parado <= 1'b1;
                    end else if (espera_entrada) begin
                        estado     <= ESPERA;
                        aguardando <= 1'b1;
                    end else if (salta) begin
                        if (alvo >= LIMITE) begin
                            pc            <= '0;
                            erro_endereco <= 1'b1;
                        end else begin
                            pc <= alvo;
                        end
                    end else begin
                        pc <= pc_mais1;
                    end
                end
                ESPERA: begin
                    if (troca_contexto) begin
                        // Save pc itself so the input instruction re-executes.
                        pc_salvo   <= pc;
                        pc         <= END_SO;
                        estado     <= EXECUTANDO;
                        aguardando <= 1'b0;
                    end else if (confirma_entrada) begin
                        pc         <= pc_mais1;
                        estado     <= EXECUTANDO;
                        aguardando <= 1'b0;
                    end
                end
                default: begin
                    // PARADO: frozen until reset.
                end
            endcase
        end
    end

endmodule

// File: doc/unidade_pc.md
Name: unidade_pc

Overview:
Program-counter and next-address stage for the 32-bit datapath. Sits directly downstream of the ULA:
- consumes its `igual` branch flag together with control-unit decode flags;
- produces the instruction address for the next cycle.
- Owns halt, input-wait stall and OS context-switch (preemption) sequencing for the lab processor.

Parameters:
- LARGURA, 32, address/data width.
- PC_INICIAL, 0, PC value loaded on reset.
- LIMITE_INSTR, 1024, instruction-memory depth in words; legal PC range is 0..LIMITE_INSTR-1.
- ENDERECO_SO, 0, OS entry address loaded on context switch.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- igual  in  1  branch-condition flag from ULA (beq/bne already resolved).
- desvio  in  1  current instruction is a conditional branch.
- salto  in  1  unconditional jump to immediate.
- salto_reg  in  1  jump to register value (jr / return from OS).
- endereco_imediato  in  LARGURA  jump/branch target.
- endereco_reg  in  LARGURA  register jump target.
- halt  in  1  halt instruction.
- espera_entrada  in  1  input instruction; stall until confirmed.
- confirma_entrada  in  1  user/IO input confirmation.
- troca_contexto  in  1  preemption request from timer/OS.
- pc  out  LARGURA  current instruction address.
- pc_salvo  out  LARGURA  PC saved at last context switch.
- parado  out  1  high while in PARADO.
- aguardando  out  1  high while in ESPERA.
- erro_endereco  out  1  one-cycle pulse on out-of-range target.

Behaviour:
- Reset (synchronous, active-high, sampled on rising clock; overrides everything, including mid-stall/halt):
  - pc=PC_INICIAL, pc_salvo=0, parado=0, aguardando=0, erro_endereco=0;
  - state=EXECUTANDO.
- All outputs are registered; pc changes only on rising clock edges.
- Next-PC update takes 1 cycle: decision inputs are sampled at edge N, and the new pc is visible after edge N.
- States: EXECUTANDO, ESPERA, PARADO. parado=(state==PARADO), aguardando=(state==ESPERA).
- EXECUTANDO priority (highest first):
  1. troca_contexto: pc_salvo<=pc+1 (wrapped), pc<=ENDERECO_SO, stay EXECUTANDO.
  2. halt: pc held, ->PARADO.
  3. espera_entrada: pc held, ->ESPERA (confirma_entrada ignored in this cycle).
  4. salto_reg: pc<=endereco_reg.
  5. salto: pc<=endereco_imediato.
  6. desvio & igual: pc<=endereco_imediato.
  7. otherwise (including desvio & !igual): pc<=pc+1.
- ESPERA:
  - troca_contexto: pc_salvo<=pc (not pc+1, so the input instruction re-executes), pc<=ENDERECO_SO, ->EXECUTANDO.
  - else confirma_entrada: pc<=pc+1, ->EXECUTANDO.
  - else hold.
  - All other decode inputs are ignored in ESPERA.
- PARADO: everything ignored (including troca_contexto); only reset exits.
- Wrap-around: pc+1 when pc==LIMITE_INSTR-1 yields 0. This is not an error.
- Out-of-range target (any selected jump/branch target >= LIMITE_INSTR):
  - pc<=0 and erro_endereco=1 for exactly that cycle;
  - state stays EXECUTANDO;
  - pc_salvo unaffected.
- erro_endereco is 0 in every other cycle.
- ENDERECO_SO must be < LIMITE_INSTR; this is not checked in hardware.
- Simultaneous assertion of multiple decode flags is resolved strictly by the priority list above.
- Arithmetic: pc+1 is computed in LARGURA bits and then reduced modulo LIMITE_INSTR.

Test Plan:
- Reset/sequential: assert reset 2 cycles, release, 3 idle cycles -> pc = 0,1,2,3; parado=aguardando=erro_endereco=0.
- Branch taken vs. not:
  - at pc=5, desvio=1, igual=1, endereco_imediato=40 -> pc=40 next cycle;
  - repeat with igual=0 -> pc=6.
  - salto and salto_reg both high (imm=10, reg=20) -> pc=20.
- Input stall:
  - at pc=7, espera_entrada=1 with confirma_entrada=1 same cycle -> pc=7, aguardando=1;
  - hold 3 cycles -> pc stays 7;
  - confirma_entrada=1 -> pc=8, aguardando=0.
- Context switch (ENDERECO_SO=100):
  - at pc=12 in EXECUTANDO, troca_contexto=1 -> pc=100, pc_salvo=13;
  - then salto_reg with endereco_reg=13 -> pc=13.
  - In ESPERA at pc=30, troca_contexto=1 -> pc_salvo=30, pc=100, aguardando=0.
- Halt and reset mid-op:
  - halt at pc=9 -> parado=1, pc=9 held through troca_contexto/salto pulses;
  - reset -> pc=0, parado=0.
- Boundaries (LIMITE_INSTR=1024):
  - pc=1023 idle -> pc=0, erro_endereco=0;
  - salto to 1024 -> pc=0, erro_endereco=1 for one cycle only.
